// File: rtl/cpu_run_ctrl.sv
// Front-panel run controller for the 16-bit CPU.
// It debounces the four board keys and sequences the CPU through reset, halt,
// single-step and run. It also counts the cycles in which the CPU is enabled
// and toggles the hex-display source.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_HOLD      = 16,
  parameter int CYC_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_n,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic [1:0]       state,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             disp_sel
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HALT  = 2'd1,
    S_STEP  = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] key_lvl;
  logic [3:0] key_lvl_prev_q;
  logic [3:0] press;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              disp_q;

  // Two-stage synchronizer for the raw key pins; keys idle high (released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic [DB_W-1:0] cnt_q;
      logic            lvl_q;

      // A new level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          lvl_q <= 1'b1;
        end else if (sync2_q[gi] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          lvl_q <= sync2_q[gi];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign key_lvl[gi] = lvl_q;
    end
  endgenerate

  // Previous debounced levels, used to turn each debounced press edge into a 1-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_lvl_prev_q <= 4'hF;
    end else begin
      key_lvl_prev_q <= key_lvl;
    end
  end

  assign press = key_lvl_prev_q & ~key_lvl;

  // Next-state logic. The reset key overrides everything, then run/halt, then step.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    if (cpu_en) begin
      cyc_d = cyc_q + 1'b1;
    end
    case (state_q)
      S_RESET: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_HALT;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_HALT: begin
        if (press[2]) begin
          state_d = S_RUN;
        end else if (press[1]) begin
          state_d = S_STEP;
        end
      end
      S_STEP:  state_d = S_HALT;
      S_RUN: begin
        // The cycle in which halt is seen is still an enabled cycle.
        if (press[2] || halt_req) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_RESET;
    endcase
    if (press[0]) begin
      state_d = S_RESET;
      hold_d  = '0;
      cyc_d   = '0;
    end
  end

  // State, reset-hold counter and executed-cycle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      hold_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
    end
  end

  // Display select flips on each display-key press, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= 1'b0;
    end else if (press[3]) begin
      disp_q <= ~disp_q;
    end
  end

  assign cpu_rst   = (state_q == S_RESET);
  assign cpu_en    = (state_q == S_STEP) || (state_q == S_RUN);
  assign state     = state_q;
  assign cycle_cnt = cyc_q;
  assign disp_sel  = disp_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl. Two instances share the key inputs: one with a
// 3-cycle reset hold and a 16-bit counter, and one with a long 16-cycle hold
// (so a second reset press can land mid-hold) and a 4-bit counter (wrap).
module tb_cpu_run_ctrl;

  localparam int D   = 4;
  localparam int RH0 = 3;
  localparam int RH1 = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       halt_req = 1'b0;

  logic        a_en, a_rst, a_disp;
  logic [1:0]  a_state;
  logic [15:0] a_cnt;
  logic        b_en, b_rst, b_disp;
  logic [1:0]  b_state;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(D), .RESET_HOLD(RH0), .CYC_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .halt_req(halt_req),
    .cpu_en(a_en), .cpu_rst(a_rst), .state(a_state), .cycle_cnt(a_cnt), .disp_sel(a_disp)
  );

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(D), .RESET_HOLD(RH1), .CYC_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .halt_req(halt_req),
    .cpu_en(b_en), .cpu_rst(b_rst), .state(b_state), .cycle_cnt(b_cnt), .disp_sel(b_disp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Key model: a debounced level flips once the last D synchronized samples
  // (raw pin values delayed by two clocks) all disagree with it.
  logic [3:0] m_hist [0:D];
  logic [3:0] m_lvl = 4'hF;
  logic [3:0] m_press = 4'h0;
  int         m_st   [0:1];
  int         m_hold [0:1];
  int         m_cnt  [0:1];
  logic       m_disp [0:1];

  logic [3:0] flip;
  logic [3:0] lvl_n, press_n;
  int         st_n   [0:1];
  int         hold_n [0:1];
  int         cnt_n  [0:1];
  logic       disp_n [0:1];

  always_comb begin
    flip    = 4'hF;
    lvl_n   = m_lvl;
    press_n = 4'h0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k <= D; k++) begin
        if (m_hist[k][i] == m_lvl[i]) flip[i] = 1'b0;
      end
      if (flip[i]) lvl_n[i] = ~m_lvl[i];
      press_n[i] = m_lvl[i] & ~lvl_n[i];
    end
    for (int j = 0; j < 2; j++) begin
      st_n[j]   = m_st[j];
      hold_n[j] = m_hold[j];
      cnt_n[j]  = (m_st[j] >= 2) ? m_cnt[j] + 1 : m_cnt[j];
      disp_n[j] = m_disp[j] ^ m_press[3];
      if (m_press[0]) begin
        st_n[j] = 0; hold_n[j] = 0; cnt_n[j] = 0;
      end else if (m_st[j] == 0) begin
        if (m_hold[j] == ((j == 0) ? RH0 : RH1) - 1) begin
          st_n[j] = 1; hold_n[j] = 0;
        end else begin
          hold_n[j] = m_hold[j] + 1;
        end
      end else if (m_st[j] == 1) begin
        if (m_press[2]) st_n[j] = 3;
        else if (m_press[1]) st_n[j] = 2;
      end else if (m_st[j] == 2) begin
        st_n[j] = 1;
      end else begin
        if (m_press[2] || halt_req) st_n[j] = 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= D; k++) m_hist[k] <= 4'hF;
      m_lvl   <= 4'hF;
      m_press <= 4'h0;
      for (int j = 0; j < 2; j++) begin
        m_st[j] <= 0; m_hold[j] <= 0; m_cnt[j] <= 0; m_disp[j] <= 1'b0;
      end
    end else begin
      m_hist[0] <= key_n;
      for (int k = 1; k <= D; k++) m_hist[k] <= m_hist[k-1];
      m_lvl   <= lvl_n;
      m_press <= press_n;
      for (int j = 0; j < 2; j++) begin
        m_st[j] <= st_n[j]; m_hold[j] <= hold_n[j]; m_cnt[j] <= cnt_n[j]; m_disp[j] <= disp_n[j];
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.state",   32'(a_state), 32'(m_st[0]));
      chk("a.cpu_en",  32'(a_en),    32'(m_st[0] >= 2));
      chk("a.cpu_rst", 32'(a_rst),   32'(m_st[0] == 0));
      chk("a.cnt",     32'(a_cnt),   32'(m_cnt[0] & 32'hFFFF));
      chk("a.disp",    32'(a_disp),  32'(m_disp[0]));
      chk("b.state",   32'(b_state), 32'(m_st[1]));
      chk("b.cpu_en",  32'(b_en),    32'(m_st[1] >= 2));
      chk("b.cpu_rst", 32'(b_rst),   32'(m_st[1] == 0));
      chk("b.cnt",     32'(b_cnt),   32'(m_cnt[1] & 32'hF));
      chk("b.disp",    32'(b_disp),  32'(m_disp[1]));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    tick(2);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    // Reset release: cpu_rst held for exactly 3 cycles.
    chk("t1.state", 32'(a_state), 0);
    chk("t1.cpu_rst", 32'(a_rst), 1);
    chk("t1.cpu_en", 32'(a_en), 0);
    chk("t1.cnt", 32'(a_cnt), 0);
    chk("t1.disp", 32'(a_disp), 0);
    tick(2);
    chk("t1.hold", 32'(a_state), 0);
    tick(1);
    chk("t1.halt", 32'(a_state), 1);
    chk("t1.rst_low", 32'(a_rst), 0);
    chk("t1.b_hold", 32'(b_state), 0);
    tick(15);
    chk("t1.b_halt", 32'(b_state), 1);

    // Single step twice: press acts 7 clocks after the pin falls.
    for (int rep = 1; rep <= 2; rep++) begin
      key_n[1] = 1'b0;
      tick(6);
      chk("t2.pre_step", 32'(a_state), 1);
      tick(1);
      chk("t2.step", 32'(a_state), 2);
      chk("t2.en", 32'(a_en), 1);
      tick(1);
      chk("t2.back_halt", 32'(a_state), 1);
      chk("t2.cnt", 32'(a_cnt), 32'(rep));
      chk("t2.b_cnt", 32'(b_cnt), 32'(rep));
      tick(2);
      key_n = 4'hF;
      tick(8);
    end

    // Glitch of 3 samples: no press.
    key_n[1] = 1'b0;
    tick(3);
    key_n = 4'hF;
    tick(10);
    chk("t3.state", 32'(a_state), 1);
    chk("t3.cnt", 32'(a_cnt), 2);

    // Run, step press ignored, then halt_req after 20 enabled cycles.
    key_n[2] = 1'b0;
    tick(6);
    chk("t4.pre_run", 32'(a_state), 1);
    tick(1);
    chk("t4.run", 32'(a_state), 3);
    chk("t4.cnt0", 32'(a_cnt), 2);
    key_n = 4'b1101;
    tick(10);
    key_n = 4'hF;
    tick(9);
    chk("t4.still_run", 32'(a_state), 3);
    chk("t4.cnt19", 32'(a_cnt), 21);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    chk("t4.halted", 32'(a_state), 1);
    chk("t4.cnt20", 32'(a_cnt), 22);
    chk("t4.b_cnt", 32'(b_cnt), 6);
    tick(3);
    chk("t4.cnt_hold", 32'(a_cnt), 22);

    // Reset and run/halt pressed together while running: reset wins.
    key_n[2] = 1'b0;
    tick(7);
    chk("t5.run", 32'(a_state), 3);
    key_n = 4'hF;
    tick(6);
    key_n = 4'b1010;
    tick(6);
    chk("t5.pre_reset", 32'(a_state), 3);
    tick(1);
    key_n = 4'hF;
    chk("t5.reset", 32'(a_state), 0);
    chk("t5.cnt", 32'(a_cnt), 0);
    chk("t5.cpu_rst", 32'(a_rst), 1);
    chk("t5.b_reset", 32'(b_state), 0);
    tick(2);
    chk("t5.hold", 32'(a_state), 0);
    tick(1);
    chk("t5.halt", 32'(a_state), 1);
    tick(1);
    key_n[0] = 1'b0;
    tick(6);
    chk("t5.b_mid_hold", 32'(b_state), 0);
    tick(1);
    key_n = 4'hF;
    chk("t5.a_reset2", 32'(a_state), 0);
    tick(3);
    chk("t5.a_halt2", 32'(a_state), 1);
    tick(6);
    chk("t5.b_restarted", 32'(b_state), 0);
    tick(7);
    chk("t5.b_halt", 32'(b_state), 1);
    chk("t5.b_cnt", 32'(b_cnt), 0);

    // Display toggle three times: 0 -> 1 -> 0 -> 1.
    for (int t = 1; t <= 3; t++) begin
      key_n[3] = 1'b0;
      tick(6);
      chk("t6.disp_pre", 32'(a_disp), 32'((t + 1) % 2));
      tick(1);
      chk("t6.disp", 32'(a_disp), 32'(t % 2));
      key_n = 4'hF;
      tick(7);
    end

    // Counter wrap on the 4-bit instance after 16 enabled cycles.
    key_n[2] = 1'b0;
    tick(7);
    key_n = 4'hF;
    chk("t6.run", 32'(a_state), 3);
    chk("t6.cnt0", 32'(a_cnt), 0);
    tick(15);
    chk("t6.b_cnt15", 32'(b_cnt), 15);
    tick(1);
    chk("t6.b_wrap", 32'(b_cnt), 0);
    chk("t6.a_cnt16", 32'(a_cnt), 16);

    // Asynchronous reset mid-run takes effect before the next clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7.cpu_en", 32'(a_en), 0);
    chk("t7.cpu_rst", 32'(a_rst), 1);
    chk("t7.cnt", 32'(a_cnt), 0);
    chk("t7.disp", 32'(a_disp), 0);
    chk("t7.b_cpu_en", 32'(b_en), 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t7.halt", 32'(a_state), 1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
